// File: rtl/piso_pkg.sv
// Shared constants for the parallel-in/serial-out serializer: FSM state codes
// and the default word width.
package piso_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

endpackage

// File: rtl/piso_serializer.sv
// LSB-first parallel-to-serial converter with gapless back-to-back frames.
// Define PISO_PARITY_EN to append one even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             live;
  logic             accept;
  logic             last_bit;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  assign last_bit = (state == ST_SHIFT) && (cnt == LAST);

  // live keeps din_ready low until the first edge after reset release
`ifdef PISO_PARITY_EN
  assign din_ready = live && ((state == ST_IDLE) || (state == ST_PARITY));
`else
  assign din_ready = live && ((state == ST_IDLE) || last_bit);
`endif

  assign accept = din_valid && din_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
      live  <= 1'b0;
`ifdef PISO_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      live <= 1'b1;
      if (accept) begin
        state <= ST_SHIFT;
        shreg <= din;
        cnt   <= '0;
`ifdef PISO_PARITY_EN
        par   <= ^din;
`endif
      end else begin
        case (state)
          ST_SHIFT: begin
            if (!last_bit) begin
              shreg <= shreg >> 1;
              cnt   <= cnt + CW'(1);
            end else begin
`ifdef PISO_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_IDLE;
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    dout = 1'b0;
    case (state)
      ST_SHIFT:  dout = shreg[0];
`ifdef PISO_PARITY_EN
      ST_PARITY: dout = par;
`endif
      default:   dout = 1'b0;
    endcase
  end

  assign dout_valid  = (state != ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign frame_start = (state == ST_SHIFT) && (cnt == '0);

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: queue-based bit-stream model plus
// directed literal checks; honours PISO_PARITY_EN.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready, dout, dout_valid, frame_start, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model: each entry is one future output cycle {frame_start, bit}
  logic [1:0] q[$];
  bit         live;

  logic cap_bit[$];
  logic cap_fs[$];
  logic cap_rdy[$];
  int   cap_cyc[$];

  piso_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit m_ready();
    return live && (q.size() <= 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      live = 1'b0;
    end else begin
      bit acc;
      acc = din_valid && m_ready();
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) q.push_back({(i == 0), din[i]});
`ifdef PISO_PARITY_EN
        q.push_back({1'b0, ^din});
`endif
      end
      live = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic ev, eb, ef;
    cyc++;
    ev = (q.size() > 0);
    eb = ev ? q[0][0] : 1'b0;
    ef = ev ? q[0][1] : 1'b0;
    chk("dout_valid",  dout_valid,  ev);
    chk("dout",        dout,        eb);
    chk("frame_start", frame_start, ef);
    chk("busy",        busy,        ev);
    chk("din_ready",   din_ready,   m_ready());
    if (dout_valid) begin
      cap_bit.push_back(dout);
      cap_fs.push_back(frame_start);
      cap_rdy.push_back(din_ready);
      cap_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk); #3;
  endtask

  task automatic cap_clear();
    cap_bit.delete(); cap_fs.delete(); cap_rdy.delete(); cap_cyc.delete();
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!m_ready() && n < 60) begin step(); n++; end
    if (n >= 60) chk({nm, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 60) begin step(); n++; end
    if (n >= 60) chk({nm, "_idle_timeout"}, 0, 1);
    step();
  endtask

  function automatic logic [W-1:0] cap_word(input int base);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) if (base + i < cap_bit.size()) w[i] = cap_bit[base + i];
    return w;
  endfunction

  initial begin
    logic exp_a5[8];
    int   nfs;
    exp_a5 = '{1, 0, 1, 0, 0, 1, 0, 1};

    // reset held with din_valid asserted
    rst = 1'b0; din_valid = 1'b1; din = 8'h3C;
    repeat (3) @(negedge clk);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_din_ready",  din_ready,  0);
    chk("rst_busy",       busy,       0);
    @(posedge clk); #3; rst = 1'b1;
    @(negedge clk);
    chk("rst_release_not_ready_yet", din_ready, 0);
    @(negedge clk);
    chk("rst_release_ready", din_ready, 1);
    step(); din_valid = 1'b0;
    wait_idle("post_reset");

    // single word A5 while din/din_valid wiggle mid-frame
    wait_ready("a5"); cap_clear();
    din = 8'hA5; din_valid = 1'b1; step();
    for (int i = 0; i < 5; i++) begin
      din = 8'($urandom); din_valid = 1'($urandom); step();
    end
    din_valid = 1'b0; din = 8'h00;
    wait_idle("a5");
    chk("a5_len", cap_bit.size(), FL);
    for (int i = 0; i < 8; i++) chk($sformatf("a5_bit%0d", i), cap_bit[i], exp_a5[i]);
    chk("a5_word", cap_word(0), 8'hA5);
    chk("a5_fs_first", cap_fs[0], 1);
    nfs = 0;
    foreach (cap_fs[i]) nfs += cap_fs[i];
    chk("a5_fs_count", nfs, 1);

    // back-to-back 0F, F0
    wait_ready("b2b"); cap_clear();
    din = 8'h0F; din_valid = 1'b1; step();
    din = 8'hF0;
    repeat (FL) step();
    din_valid = 1'b0;
    wait_idle("b2b");
    chk("b2b_len", cap_bit.size(), 2 * FL);
    if (cap_bit.size() == 2 * FL) begin
      chk("b2b_contig", cap_cyc[2*FL-1] - cap_cyc[0], 2 * FL - 1);
      chk("b2b_word0", cap_word(0),  8'h0F);
      chk("b2b_word1", cap_word(FL), 8'hF0);
      chk("b2b_fs0", cap_fs[0],  1);
      chk("b2b_fs1", cap_fs[FL], 1);
      chk("b2b_rdy0", cap_rdy[FL-1],   1);
      chk("b2b_rdy1", cap_rdy[2*FL-1], 1);
      nfs = 0;
      foreach (cap_rdy[i]) nfs += cap_rdy[i];
      chk("b2b_rdy_count", nfs, 2);
    end

`ifdef PISO_PARITY_EN
    wait_ready("par07"); cap_clear();
    din = 8'h07; din_valid = 1'b1; step(); din_valid = 1'b0;
    wait_idle("par07");
    chk("par07_word", cap_word(0), 8'h07);
    chk("par07_parity", cap_bit[W], 1);
    chk("par07_rdy_last", cap_rdy[W], 1);
    chk("par07_rdy_data", cap_rdy[W-1], 0);
    chk("par07_fs_parity", cap_fs[W], 0);
    wait_ready("par03"); cap_clear();
    din = 8'h03; din_valid = 1'b1; step(); din_valid = 1'b0;
    wait_idle("par03");
    chk("par03_word", cap_word(0), 8'h03);
    chk("par03_parity", cap_bit[W], 0);
`endif

    // reset asserted during bit 4 of FF
    wait_ready("abort"); cap_clear();
    din = 8'hFF; din_valid = 1'b1; step(); din_valid = 1'b0;
    repeat (4) step();
    rst = 1'b0; #1;
    chk("abort_valid", dout_valid, 0);
    chk("abort_busy",  busy, 0);
    chk("abort_dout",  dout, 0);
    chk("abort_ready", din_ready, 0);
    chk("abort_bits_before", cap_bit.size(), 4);
    step(); rst = 1'b1;
    repeat (3) step();
    chk("abort_no_more_bits", cap_bit.size(), 4);
    wait_ready("after_abort"); cap_clear();
    din = 8'h01; din_valid = 1'b1; step(); din_valid = 1'b0;
    wait_idle("after_abort");
    chk("after_abort_len", cap_bit.size(), FL);
    chk("after_abort_word", cap_word(0), 8'h01);

    // random traffic with occasional reset pulses
    for (int i = 0; i < 500; i++) begin
      din = 8'($urandom);
      din_valid = ($urandom % 4) != 0;
      if ($urandom_range(0, 149) == 0) rst = 1'b0;
      else rst = 1'b1;
      step();
    end
    rst = 1'b1; din_valid = 1'b0;
    wait_idle("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
